// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam int                IMEM_BYTES_DEF = 28;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'h0;

  localparam int BUF_DEPTH = 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs sitting between the fetch PC and decode.
// Flush wins over push and pop; the head keeps presenting its last contents when empty.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_entry,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Pull the write pointer back rather than moving the read pointer, so the
      // (now invalid) head output does not change.
      wr_ptr  <= rd_ptr;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, buffers fetched words, handles redirects.
// Optional misaligned-fetch trap is enabled with `define FETCH_ALIGN_CHECK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | fetching sequentially while the PC is inside instruction memory
// ST_DONE  | PC ran past the last word; buffered entries still drain
// ST_FAULT | misaligned fetch trapped; waits for reset or an aligned redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                IMEM_BYTES = IMEM_BYTES_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr_code,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_done,
  output logic               misalign_fault
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;

  logic              push;
  logic              pop;
  logic              flush;
  logic              room;
  logic              pc_aligned_ok;
  logic              redirect_bad;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;
  logic [CNT_W-1:0]  count;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_aligned_ok = is_aligned(pc_q);
  assign redirect_bad  = !is_aligned(redirect_pc);
`else
  assign pc_aligned_ok = 1'b1;
  assign redirect_bad  = 1'b0;
`endif

  assign pop  = instr_valid && instr_ready;
  // A full buffer can still take a new word when the head leaves this cycle.
  assign room = (count < CNT_W'(BUF_DEPTH)) || pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    push      = 1'b0;
    flush     = 1'b0;

    if (redirect) begin
      flush     = 1'b1;
      pc_nxt    = redirect_pc;
      state_nxt = redirect_bad ? ST_FAULT : ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (pc_q > LAST_PC) begin
            state_nxt = ST_DONE;
          end else if (room) begin
            if (!pc_aligned_ok) begin
              state_nxt = ST_FAULT;
            end else begin
              push   = 1'b1;
              pc_nxt = pc_q + ADDR_W'(4);
            end
          end
        end
        ST_DONE:  state_nxt = ST_DONE;
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = instr_code;

  fetch_buffer u_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign pc          = pc_q;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
  assign instr_valid = (count != '0);
  assign fetch_done  = (state == ST_DONE);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_fault = (state == ST_FAULT);
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch unit and a byte-array memory.
module tb_instr_fetch;

  localparam int MEM_BYTES = 28;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr_code;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_done;
  logic        misalign_fault;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:MEM_BYTES-1];

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a < 32'(MEM_BYTES)) return mem[a[4:0]];
    return 8'h00;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return {rd_byte(a), rd_byte(a + 32'd1), rd_byte(a + 32'd2), rd_byte(a + 32'd3)};
  endfunction

  assign instr_code = fetch_word(pc);

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instr_code     (instr_code),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_done     (fetch_done),
    .misalign_fault (misalign_fault)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0; redirect_pc = 32'h0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
    tick; tick;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %0h expected 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %0h expected 0", instr_pc); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", fetch_done); end
    checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", misalign_fault); end
    reset = 1'b0;
  endtask

  task automatic test_stream;
    do_reset;
    instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, instr_valid); end
      checks++; if (instr_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %0h expected %0h", i, instr_pc, 4 * i); end
      checks++; if (instr_out !== fetch_word(32'(4 * i))) begin errors++; $display("FAIL stream_instr[%0d]: got %0h expected %0h", i, instr_out, fetch_word(32'(4 * i))); end
    end
    tick;
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL stream_done: got %0b expected 1", fetch_done); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %0b expected 0", instr_valid); end
    checks++; if (pc !== 32'd28) begin errors++; $display("FAIL stream_end_pc: got %0h expected 1c", pc); end
  endtask

  task automatic test_backpressure;
    do_reset;
    instr_ready = 1'b0;
    repeat (5) tick;
    checks++; if (pc !== 32'd8) begin errors++; $display("FAIL bp_pc: got %0h expected 8", pc); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL bp_head: got %0h expected 0", instr_pc); end
    instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_release[%0d]: got valid=%0b pc=%0h expected valid=1 pc=%0h", i, instr_valid, instr_pc, 4 * i); end
    end
  endtask

  task automatic test_redirect_flush;
    do_reset;
    instr_ready = 1'b0;
    tick; tick;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'd12;
    tick;
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", instr_valid); end
    checks++; if (pc !== 32'd12) begin errors++; $display("FAIL flush_pc: got %0h expected c", pc); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(12 + 4 * i)) begin errors++; $display("FAIL flush_seq[%0d]: got valid=%0b pc=%0h expected valid=1 pc=%0h", i, instr_valid, instr_pc, 12 + 4 * i); end
    end
  endtask

  task automatic test_redirect_from_done;
    int n;
    do_reset;
    instr_ready = 1'b1;
    n = 0;
    while (fetch_done !== 1'b1 && n < 30) begin tick; n++; end
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL done_timeout: got %0b expected 1 within 30 cycles", fetch_done); end
    redirect = 1'b1; redirect_pc = 32'd4;
    tick;
    redirect = 1'b0;
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL rd_done_clear: got %0b expected 0", fetch_done); end
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL rd_pc: got %0h expected 4", pc); end
    for (int i = 1; i < 7; i++) begin
      tick;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i)) begin errors++; $display("FAIL rd_seq[%0d]: got valid=%0b pc=%0h expected valid=1 pc=%0h", i, instr_valid, instr_pc, 4 * i); end
    end
    tick;
    checks++; if (fetch_done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL rd_done_again: got done=%0b valid=%0b expected done=1 valid=0", fetch_done, instr_valid); end
  endtask

  task automatic test_misalign;
    do_reset;
    instr_ready = 1'b1;
    tick;
    redirect = 1'b1; redirect_pc = 32'd7;
    tick;
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got %0b expected 0", instr_valid); end
`ifdef FETCH_ALIGN_CHECK_EN
    tick;
    checks++; if (misalign_fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %0b expected 1", misalign_fault); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_no_deliver: got %0b expected 0", instr_valid); end
    redirect = 1'b1; redirect_pc = 32'd8;
    tick;
    redirect = 1'b0;
    checks++; if (misalign_fault !== 1'b0 || pc !== 32'd8) begin errors++; $display("FAIL mis_clear: got fault=%0b pc=%0h expected fault=0 pc=8", misalign_fault, pc); end
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd8) begin errors++; $display("FAIL mis_recover: got valid=%0b pc=%0h expected valid=1 pc=8", instr_valid, instr_pc); end
    checks++; if (instr_out !== fetch_word(32'd8)) begin errors++; $display("FAIL mis_recover_instr: got %0h expected %0h", instr_out, fetch_word(32'd8)); end
`else
    checks++; if (pc !== 32'd7 || misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_pc: got pc=%0h fault=%0b expected pc=7 fault=0", pc, misalign_fault); end
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd7) begin errors++; $display("FAIL mis_deliver: got valid=%0b pc=%0h expected valid=1 pc=7", instr_valid, instr_pc); end
    checks++; if (instr_out !== fetch_word(32'd7)) begin errors++; $display("FAIL mis_instr: got %0h expected %0h", instr_out, fetch_word(32'd7)); end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset;
    instr_ready = 1'b0;
    repeat (3) tick;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'd8) begin errors++; $display("FAIL rm_pre: got valid=%0b pc=%0h expected valid=1 pc=8", instr_valid, pc); end
    reset = 1'b1;
    tick;
    checks++; if (instr_valid !== 1'b0 || pc !== 32'd0) begin errors++; $display("FAIL rm_reset: got valid=%0b pc=%0h expected valid=0 pc=0", instr_valid, pc); end
    reset = 1'b0;
    tick;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin errors++; $display("FAIL rm_first: got valid=%0b pc=%0h expected valid=1 pc=0", instr_valid, instr_pc); end
  endtask

  // Reference: a queue of {pc, word} as the buffer, plain PC arithmetic, and a
  // mode number (0 fetching, 1 past end, 2 trapped).
  task automatic test_random;
    logic [63:0] q[$];
    logic [31:0] m_pc;
    int          mode;
    logic        r_rst, r_rdy, r_redir;
    logic [31:0] rpc;
    do_reset;
    q.delete(); m_pc = 32'h0; mode = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %0h expected %0h", cyc, pc, m_pc); end
      checks++; if (instr_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", cyc, instr_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if ({instr_pc, instr_out} !== q[0]) begin errors++; $display("FAIL rnd_head@%0d: got %0h:%0h expected %0h:%0h", cyc, instr_pc, instr_out, q[0][63:32], q[0][31:0]); end
      end
      checks++; if (fetch_done !== (mode == 1)) begin errors++; $display("FAIL rnd_done@%0d: got %0b expected %0b", cyc, fetch_done, mode == 1); end
      checks++; if (misalign_fault !== (mode == 2)) begin errors++; $display("FAIL rnd_fault@%0d: got %0b expected %0b", cyc, misalign_fault, mode == 2); end

      r_rst   = ($urandom_range(0, 79) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = 32'd28;
        1:       rpc = 32'($urandom_range(0, 27));
        2:       rpc = 32'hFFFF_FFF0;
        default: rpc = 32'($urandom_range(0, 6)) * 32'd4;
      endcase
      reset = r_rst; instr_ready = r_rdy; redirect = r_redir; redirect_pc = rpc;

      if (r_rst) begin
        q.delete(); m_pc = 32'h0; mode = 0;
      end else if (r_redir) begin
        q.delete(); m_pc = rpc;
        mode = (ALIGN_CHK && rpc[1:0] != 2'b00) ? 2 : 0;
      end else begin
        if (q.size() > 0 && r_rdy) void'(q.pop_front());
        if (mode == 0) begin
          if (m_pc > 32'(MEM_BYTES - 4)) mode = 1;
          else if (q.size() < 2) begin
            if (ALIGN_CHK && m_pc[1:0] != 2'b00) mode = 2;
            else begin
              q.push_back({m_pc, fetch_word(m_pc)});
              m_pc = m_pc + 32'd4;
            end
          end
        end
      end
      tick;
    end
    reset = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_flush;
    test_redirect_from_done;
    test_misalign;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
